// File: rtl/ttl_updn_counter_ireg.sv
// Parametrised up/down binary counter fed from a parallel input register, with cascade enable and ripple carry.
// Latency: in->ireg 1 cycle, ireg->cnt 1 cycle (2 cycles in->cnt); rco is combinational from cnt, cent and up.
// Backpressure: none; counting stalls while ccken is high or cent is low, and loads and holds never drop state.
module ttl_updn_counter_ireg #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] MAXVAL = {WIDTH{1'b1}}
) (
    input  logic             cck,
    input  logic             cclr,
    input  logic             rcken,
    input  logic [WIDTH-1:0] in,
    input  logic             cload,
    input  logic             ccken,
    input  logic             cent,
    input  logic             up,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] ireg,
    output logic             rco
);

    logic             at_zero;
    logic             at_or_above_max;
    logic             at_max;
    logic             terminal;
    logic [WIDTH-1:0] cnt_step;

    assign at_zero         = (cnt == '0);
    assign at_max          = (cnt == MAXVAL);
    // A loaded value above the modulus must still wrap to zero on the next up count.
    assign at_or_above_max = (cnt >= MAXVAL);

    always_comb begin
        cnt_step = cnt;
        if (up) begin
            cnt_step = at_or_above_max ? '0 : cnt + WIDTH'(1);
        end else begin
            cnt_step = at_zero ? MAXVAL : cnt - WIDTH'(1);
        end
    end

    // Terminal count ignores ccken so a stalled stage still enables the next one in a chain.
    assign terminal = up ? at_max : at_zero;
    assign rco      = ~(cent & terminal);

    always_ff @(posedge cck) begin
        if (!cclr) begin
            cnt  <= '0;
            ireg <= '0;
        end else begin
            if (!rcken) begin
                ireg <= in;
            end
            if (!cload) begin
                cnt <= ireg;
            end else if (!ccken && cent) begin
                cnt <= cnt_step;
            end
        end
    end

endmodule

// File: tb/tb_ttl_updn_counter_ireg.sv
// Scoreboarded random and directed bench: 8-bit counter, 4-bit modulo-10 counter and a two-stage 4-bit cascade.
module tb_ttl_updn_counter_ireg;

    logic       cck = 1'b0;
    logic       cclr = 1'b0, rcken = 1'b1, cload = 1'b1, ccken = 1'b1, cent = 1'b0, up = 1'b1;
    logic [7:0] din = 8'h00;

    logic [7:0] cnt8, ireg8;
    logic       rco8;
    logic [3:0] cnt4, ireg4, cnt_lo, ireg_lo, cnt_hi, ireg_hi;
    logic       rco4, rco_lo, rco_hi;

    always #5 cck = ~cck;

    ttl_updn_counter_ireg #(.WIDTH(8)) u8 (
        .cck(cck), .cclr(cclr), .rcken(rcken), .in(din), .cload(cload), .ccken(ccken),
        .cent(cent), .up(up), .cnt(cnt8), .ireg(ireg8), .rco(rco8));

    ttl_updn_counter_ireg #(.WIDTH(4), .MAXVAL(4'd9)) u4 (
        .cck(cck), .cclr(cclr), .rcken(rcken), .in(din[3:0]), .cload(cload), .ccken(ccken),
        .cent(cent), .up(up), .cnt(cnt4), .ireg(ireg4), .rco(rco4));

    ttl_updn_counter_ireg #(.WIDTH(4)) ulo (
        .cck(cck), .cclr(cclr), .rcken(rcken), .in(din[3:0]), .cload(cload), .ccken(ccken),
        .cent(cent), .up(up), .cnt(cnt_lo), .ireg(ireg_lo), .rco(rco_lo));

    ttl_updn_counter_ireg #(.WIDTH(4)) uhi (
        .cck(cck), .cclr(cclr), .rcken(rcken), .in(din[7:4]), .cload(cload), .ccken(rco_lo),
        .cent(cent), .up(up), .cnt(cnt_hi), .ireg(ireg_hi), .rco(rco_hi));

    typedef struct {
        int unsigned c8, i8, c4, i4, cc, ci;
        bit          r8, r4, rlo, rhi;
    } exp_t;

    exp_t exp_q[$];
    int   nchk = 0;
    int   nerr = 0;

    // Reference state, kept as plain integers.
    int unsigned m_c8 = 0, m_i8 = 0, m_c4 = 0, m_i4 = 0, m_lo = 0, m_ilo = 0, m_hi = 0, m_ihi = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned next_cnt(int unsigned c, int unsigned ir, bit clr, bit ld,
                                             bit cke, bit ce, bit u, int unsigned mx);
        if (!clr) return 0;
        if (!ld) return ir;
        if (cke || !ce) return c;
        if (u) return (c >= mx) ? 0 : c + 1;
        return (c == 0) ? mx : c - 1;
    endfunction

    function automatic int unsigned next_ireg(int unsigned ir, bit clr, bit rck, int unsigned d);
        if (!clr) return 0;
        return rck ? ir : d;
    endfunction

    function automatic bit rco_of(int unsigned c, bit ce, bit u, int unsigned mx);
        return !(ce && (u ? (c == mx) : (c == 0)));
    endfunction

    // One clock of stimulus: drive at negedge, advance the model, queue what the next edge must show.
    task automatic cyc(input bit clr, input bit rck, input logic [7:0] d, input bit ld,
                       input bit cke, input bit ce, input bit u);
        exp_t        e;
        bit          lo_rco_pre;
        int unsigned dv;
        @(negedge cck);
        cclr = clr; rcken = rck; din = d; cload = ld; ccken = cke; cent = ce; up = u;
        dv = rck ? 0 : int'(d);
        lo_rco_pre = rco_of(m_lo, ce, u, 15);
        m_c8 = next_cnt(m_c8, m_i8, clr, ld, cke, ce, u, 255);
        m_c4 = next_cnt(m_c4, m_i4, clr, ld, cke, ce, u, 9);
        m_lo = next_cnt(m_lo, m_ilo, clr, ld, cke, ce, u, 15);
        m_hi = next_cnt(m_hi, m_ihi, clr, ld, lo_rco_pre, ce, u, 15);
        m_i8  = next_ireg(m_i8, clr, rck, dv);
        m_i4  = next_ireg(m_i4, clr, rck, dv % 16);
        m_ilo = next_ireg(m_ilo, clr, rck, dv % 16);
        m_ihi = next_ireg(m_ihi, clr, rck, dv / 16);
        e.c8 = m_c8; e.i8 = m_i8; e.r8 = rco_of(m_c8, ce, u, 255);
        e.c4 = m_c4; e.i4 = m_i4; e.r4 = rco_of(m_c4, ce, u, 9);
        e.cc = m_hi * 16 + m_lo; e.ci = m_ihi * 16 + m_ilo;
        e.rlo = rco_of(m_lo, ce, u, 15); e.rhi = rco_of(m_hi, ce, u, 15);
        exp_q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge cck);
        #2;
    endtask

    // Monitor: every edge that has a queued expectation is compared just after it.
    always @(posedge cck) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cnt8",  cnt8,  e.c8);
            chk("ireg8", ireg8, e.i8);
            chk("rco8",  rco8,  e.r8);
            chk("cnt4",  cnt4,  e.c4);
            chk("ireg4", ireg4, e.i4);
            chk("rco4",  rco4,  e.r4);
            chk("casc_cnt",  {cnt_hi, cnt_lo},   e.cc);
            chk("casc_ireg", {ireg_hi, ireg_lo}, e.ci);
            chk("rco_lo", rco_lo, e.rlo);
            chk("rco_hi", rco_hi, e.rhi);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected finish before 1000000");
        $fatal(1);
    end

    initial begin
        // Reset, register load, counter load.
        cyc(0, 1, 8'h00, 1, 1, 0, 1);
        after_edge(); chk("reset_cnt", cnt8, 8'h00); chk("reset_ireg", ireg8, 8'h00);
        cyc(1, 0, 8'hF0, 1, 1, 0, 1);
        after_edge(); chk("load_ireg", ireg8, 8'hF0); chk("load_ireg_cnt", cnt8, 8'h00);
        cyc(1, 1, 8'bx, 0, 1, 0, 1);
        after_edge(); chk("load_cnt", cnt8, 8'hF0);

        // Up count to terminal and wrap.
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 1, 8'bx, 1, 0, 1, 1);
            after_edge();
            if (i == 14) begin chk("up14_cnt", cnt8, 8'hFE); chk("up14_rco", rco8, 1); end
            if (i == 15) begin chk("up15_cnt", cnt8, 8'hFF); chk("up15_rco", rco8, 0); end
            if (i == 16) begin chk("wrap_cnt", cnt8, 8'h00); chk("wrap_rco", rco8, 1); end
        end

        // Down count through zero to MAXVAL=9 on the 4-bit stage.
        cyc(1, 0, 8'h02, 1, 1, 1, 0);
        cyc(1, 1, 8'bx, 0, 1, 1, 0);
        after_edge(); chk("dn_load", cnt4, 4'd2);
        cyc(1, 1, 8'bx, 1, 0, 1, 0); after_edge(); chk("dn_1", cnt4, 4'd1);
        cyc(1, 1, 8'bx, 1, 0, 1, 0); after_edge(); chk("dn_0", cnt4, 4'd0); chk("dn_0_rco", rco4, 0);
        cyc(1, 1, 8'bx, 1, 0, 1, 0); after_edge(); chk("dn_9", cnt4, 4'd9); chk("dn_9_rco", rco4, 1);
        cyc(1, 1, 8'bx, 1, 1, 1, 1); after_edge(); chk("up_at9_rco", rco4, 0);
        cyc(1, 1, 8'bx, 1, 0, 1, 1); after_edge(); chk("up_9_wrap", cnt4, 4'd0);

        // cent=0 blocks counting and rco at terminal.
        cyc(1, 0, 8'hFF, 1, 1, 1, 1);
        cyc(1, 1, 8'bx, 0, 1, 1, 1);
        cyc(1, 1, 8'bx, 1, 0, 0, 1);
        after_edge(); chk("cent0_hold", cnt8, 8'hFF); chk("cent0_rco", rco8, 1);
        // Load beats count; simultaneous register load takes the new input.
        cyc(1, 0, 8'h02, 1, 1, 1, 1);
        cyc(1, 0, 8'h05, 0, 1, 1, 1);
        after_edge(); chk("prio_pre_cnt", cnt8, 8'h02); chk("prio_pre_ireg", ireg8, 8'h05);
        cyc(1, 0, 8'h07, 0, 0, 1, 1);
        after_edge(); chk("prio_cnt", cnt8, 8'h05); chk("prio_ireg", ireg8, 8'h07);

        // Cascade from 0x0E.
        cyc(1, 0, 8'h0E, 1, 1, 1, 1);
        cyc(1, 1, 8'bx, 0, 1, 1, 1);
        cyc(1, 1, 8'bx, 1, 0, 1, 1);
        after_edge(); chk("casc_0f", {cnt_hi, cnt_lo}, 8'h0F); chk("casc_0f_rco_lo", rco_lo, 0);
        cyc(1, 1, 8'bx, 1, 0, 1, 1);
        after_edge(); chk("casc_10", {cnt_hi, cnt_lo}, 8'h10);

        // Reset overrides simultaneous loads.
        cyc(1, 0, 8'h55, 1, 1, 1, 1);
        cyc(1, 0, 8'hAA, 0, 1, 1, 1);
        after_edge(); chk("rst_pre_cnt", cnt8, 8'h55); chk("rst_pre_ireg", ireg8, 8'hAA);
        cyc(0, 0, 8'h33, 0, 0, 1, 1);
        after_edge(); chk("rst_prio_cnt", cnt8, 8'h00); chk("rst_prio_ireg", ireg8, 8'h00);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit          clr, rck, ld, cke, ce, u;
            logic [7:0]  d;
            clr = ($urandom_range(0, 59) != 0);
            rck = ($urandom_range(0, 3) != 0);
            d   = rck ? 8'bx : 8'($urandom);
            ld  = ($urandom_range(0, 9) != 0);
            cke = ($urandom_range(0, 3) == 0);
            ce  = ($urandom_range(0, 5) != 0);
            u   = ($urandom_range(0, 2) != 0);
            cyc(clr, rck, d, ld, cke, ce, u);
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) after_edge();
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
